conv_encoder_k3: RTL and testbench

Rate-1/2, constraint-length-3 convolutional encoder (generators 7,5 octal) that produces the coded stream consumed by the Viterbi decoder chain. It accepts one MSG_BITS-bit message block per handshake and encodes it MSB first. It appends two zero tail bits so the trellis terminates in state 00. For each trellis step it emits one coded bit pair, both as hard bits and as BPSK-mapped signed symbols ready for the channel model or the decoder's edge-metric inputs.

---
 rtl/conv_encoder_k3.sv | 120 ++++++++++++
 tb/tb_conv_encoder_k3.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_k3.sv
// Rate-1/2, K=3 convolutional encoder (g1=7, g2=5 octal) with two-bit zero tail.
// Emits one registered coded pair per trellis step, as hard bits and BPSK symbols.
module conv_encoder_k3 #(
    parameter int MSG_BITS = 6,
    parameter int SYM_W    = 8,
    parameter int AMP      = 64
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MSG_BITS-1:0] in_msg,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_c1,
    output logic                out_c2,
    output logic [SYM_W-1:0]    out_s1,
    output logic [SYM_W-1:0]    out_s2,
    output logic [3:0]          out_step,
    output logic                out_last
);

    localparam logic [3:0]       LAST_STEP = 4'(MSG_BITS + 1);
    localparam logic [SYM_W-1:0] SYM_POS   = SYM_W'(AMP);
    localparam logic [SYM_W-1:0] SYM_NEG   = SYM_W'(-AMP);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next;

    // r_sh[MSB] is the input bit u of the pair currently on the outputs;
    // r_s0 is the encoder state bit that preceded it. The older state bit is
    // never needed again once the next pair is computed, so it is not stored.
    logic [MSG_BITS-1:0] r_sh;
    logic                r_s0;
    logic                r_c1;
    logic                r_c2;
    logic [SYM_W-1:0]    r_sym1;
    logic [SYM_W-1:0]    r_sym2;
    logic [3:0]          r_step;

    logic                w_accept;
    logic                w_xfer;
    logic                w_final;
    logic                w_u_cur;
    logic                w_u_nxt;
    logic [MSG_BITS-1:0] w_sh_nxt;
    logic                w_c1_nxt;
    logic                w_c2_nxt;

    assign w_accept = (r_state == ST_IDLE) && in_valid;
    assign w_xfer   = (r_state == ST_SEND) && out_ready;
    assign w_final  = (r_step == LAST_STEP);

    // Shifting left fills zeros, which supplies the tail bits for free.
    assign w_sh_nxt = r_sh << 1;
    assign w_u_cur  = r_sh[MSG_BITS-1];
    assign w_u_nxt  = w_sh_nxt[MSG_BITS-1];
    assign w_c1_nxt = w_u_nxt ^ w_u_cur ^ r_s0;
    assign w_c2_nxt = w_u_nxt ^ r_s0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_next = ST_SEND;
            ST_SEND: if (out_ready && w_final) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sh   <= '0;
            r_s0   <= 1'b0;
            r_c1   <= 1'b0;
            r_c2   <= 1'b0;
            r_sym1 <= '0;
            r_sym2 <= '0;
            r_step <= '0;
        end else if (w_accept) begin
            r_sh   <= in_msg;
            r_s0   <= 1'b0;
            r_c1   <= in_msg[MSG_BITS-1];
            r_c2   <= in_msg[MSG_BITS-1];
            r_sym1 <= in_msg[MSG_BITS-1] ? SYM_NEG : SYM_POS;
            r_sym2 <= in_msg[MSG_BITS-1] ? SYM_NEG : SYM_POS;
            r_step <= '0;
        end else if (w_xfer && !w_final) begin
            r_sh   <= w_sh_nxt;
            r_s0   <= w_u_cur;
            r_c1   <= w_c1_nxt;
            r_c2   <= w_c2_nxt;
            r_sym1 <= w_c1_nxt ? SYM_NEG : SYM_POS;
            r_sym2 <= w_c2_nxt ? SYM_NEG : SYM_POS;
            r_step <= r_step + 4'd1;
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_SEND);
    assign out_last  = (r_state == ST_SEND) && w_final;
    assign out_c1    = r_c1;
    assign out_c2    = r_c2;
    assign out_s1    = r_sym1;
    assign out_s2    = r_sym2;
    assign out_step  = r_step;

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Self-checking bench for conv_encoder_k3: a convolution-sum reference model
// feeds a scoreboard that is compared against every handshaked output pair.
module tb_conv_encoder_k3;

    localparam int M     = 6;
    localparam int SYM_W = 8;
    localparam int AMP   = 64;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [M-1:0]     in_msg = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_c1;
    logic             out_c2;
    logic [SYM_W-1:0] out_s1;
    logic [SYM_W-1:0] out_s2;
    logic [3:0]       out_step;
    logic             out_last;

    conv_encoder_k3 #(.MSG_BITS(M), .SYM_W(SYM_W), .AMP(AMP)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_msg(in_msg),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c1(out_c1), .out_c2(out_c2), .out_s1(out_s1), .out_s2(out_s2),
        .out_step(out_step), .out_last(out_last)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic c1;
        logic c2;
        int   step;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_n = 0;
    int   acc_cyc[$];
    int   rdy_mode = 0;
    int   rcnt = 0;
    logic [15:0] obs_pairs;
    int   obs_n;
    int   obs_last_n;
    int   obs_last_step;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, $signed(act), $signed(exp), $time);
        end
    endtask

    // Input bit j of the block: message MSB first, zeros before and after.
    function automatic int ubit(logic [M-1:0] msg, int j);
        if (j < 0 || j >= M) return 0;
        return int'(msg[M-1-j]);
    endfunction

    function automatic logic [1:0] pair_at(logic [M-1:0] msg, int k);
        int u0, u1, u2;
        u0 = ubit(msg, k);
        u1 = ubit(msg, k - 1);
        u2 = ubit(msg, k - 2);
        return {1'(u0 ^ u1 ^ u2), 1'(u0 ^ u2)};
    endfunction

    function automatic logic [15:0] model_block(logic [M-1:0] msg);
        logic [15:0] r = '0;
        for (int k = 0; k < M + 2; k++) r = {r[13:0], pair_at(msg, k)};
        return r;
    endfunction

    function automatic int sym_of(logic c);
        return c ? -AMP : AMP;
    endfunction

    always @(posedge CLK) cyc++;

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: begin out_ready = ((rcnt % 3) == 0); rcnt++; end
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Compare process: checks DUT against the scoreboard once per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST) begin
                q.delete();
            end else begin
                chk("busy", 32'(out_valid), 32'(q.size() != 0));
                chk("in_ready", 32'(in_ready), 32'(!out_valid));
                if (out_valid && q.size() != 0) begin
                    e = q[0];
                    chk("c1", 32'(out_c1), 32'(e.c1));
                    chk("c2", 32'(out_c2), 32'(e.c2));
                    chk("s1", 32'(int'($signed(out_s1))), 32'(sym_of(e.c1)));
                    chk("s2", 32'(int'($signed(out_s2))), 32'(sym_of(e.c2)));
                    chk("step", 32'(out_step), 32'(e.step));
                    chk("last", 32'(out_last), 32'(e.step == M + 1));
                    if (out_ready) begin
                        void'(q.pop_front());
                        obs_pairs = {obs_pairs[13:0], out_c1, out_c2};
                        obs_n++;
                        if (out_last) begin
                            obs_last_n++;
                            obs_last_step = int'(out_step);
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    for (int k = 0; k < M + 2; k++) begin
                        logic [1:0] p;
                        p = pair_at(in_msg, k);
                        e.c1 = p[1];
                        e.c2 = p[0];
                        e.step = k;
                        q.push_back(e);
                    end
                    acc_n++;
                    acc_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic clear_obs();
        obs_pairs = '0;
        obs_n = 0;
        obs_last_n = 0;
        obs_last_step = -1;
    endtask

    task automatic send(input logic [M-1:0] msg);
        int n0, n;
        @(posedge CLK);
        #1;
        in_valid = 1'b1;
        in_msg = msg;
        n0 = acc_n;
        n = 0;
        do begin @(posedge CLK); n++; end while (acc_n == n0 && n < 100);
        #1;
        in_valid = 1'b0;
        if (acc_n == n0) chk("accept_timeout", 32'(acc_n), 32'(n0 + 1));
    endtask

    task automatic wait_done();
        int n = 0;
        do begin @(posedge CLK); #1; n++; end while ((q.size() != 0 || out_valid) && n < 300);
        if (q.size() != 0 || out_valid) chk("done_timeout", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clear_obs();
        chk("model_101100", 32'(model_block(6'b101100)), 32'h0000_E170);
        chk("model_111111", 32'(model_block(6'b111111)), 32'h0000_DAA7);

        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_c", 32'({out_c1, out_c2, out_last}), 32'd0);
        chk("rst_sym", 32'({out_s1, out_s2}), 32'd0);
        chk("rst_step", 32'(out_step), 32'd0);

        // Block 101100, sink always ready
        clear_obs();
        send(6'b101100);
        wait_done();
        chk("blk1_pairs", 32'(obs_pairs), 32'h0000_E170);
        chk("blk1_count", 32'(obs_n), 32'd8);
        chk("blk1_last_n", 32'(obs_last_n), 32'd1);
        chk("blk1_last_step", 32'(obs_last_step), 32'd7);

        // All ones, then all zeros proves the tail flushed to state 00
        clear_obs();
        send(6'b111111);
        wait_done();
        chk("ones_pairs", 32'(obs_pairs), 32'h0000_DAA7);
        clear_obs();
        send(6'b000000);
        wait_done();
        chk("zeros_pairs", 32'(obs_pairs), 32'h0000_0000);
        chk("zeros_count", 32'(obs_n), 32'd8);

        // Backpressure
        clear_obs();
        rcnt = 0;
        rdy_mode = 1;
        send(6'b101100);
        wait_done();
        rdy_mode = 0;
        chk("bp_pairs", 32'(obs_pairs), 32'h0000_E170);
        chk("bp_last_n", 32'(obs_last_n), 32'd1);

        // Back-to-back blocks with in_valid held high
        @(posedge CLK);
        #1;
        in_valid = 1'b1;
        in_msg = 6'b111111;
        n = 0;
        do begin @(posedge CLK); n++; end while (acc_n < 5 && n < 100);
        #1;
        in_msg = 6'b101100;
        clear_obs();
        n = 0;
        do begin @(posedge CLK); n++; end while (acc_n < 6 && n < 100);
        #1;
        in_valid = 1'b0;
        chk("b2b_accepts", 32'(acc_n), 32'd6);
        if (acc_cyc.size() >= 2)
            chk("b2b_period", 32'(acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2]), 32'(M + 3));
        wait_done();
        chk("b2b_second", 32'(obs_pairs), 32'h0000_E170);

        // Reset in the middle of a block at step 3
        send(6'b101100);
        n = 0;
        while (!(out_valid && out_step == 4'd3) && n < 50) begin @(posedge CLK); #1; n++; end
        chk("mid_reached_step3", 32'(out_step), 32'd3);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd1);
        chk("mid_last", 32'(out_last), 32'd0);
        clear_obs();
        send(6'b101100);
        wait_done();
        chk("mid_after_pairs", 32'(obs_pairs), 32'h0000_E170);
        chk("mid_after_last", 32'(obs_last_step), 32'd7);

        // Randomized blocks, random sink stalls, occasional resets
        rdy_mode = 2;
        for (int b = 0; b < 40; b++) begin
            repeat ($urandom_range(0, 3)) @(posedge CLK);
            send(M'($urandom));
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(0, 6)) @(posedge CLK);
                do_reset();
            end
            wait_done();
        end
        rdy_mode = 0;
        repeat (2) @(posedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
